// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop/lap buttons drive an FSM.
// Define STOPWATCH_LAP_EN to build the LAP state and the LapN debouncer.

module stopwatch_deb #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic Clk,
  input  logic RES,
  input  logic i_btn_n,
  output logic o_press
);
  localparam logic [7:0] LP_DEB = 8'(DEB_CYCLES);

  logic [1:0] r_sync;
  logic       r_lvl;
  logic [7:0] r_cnt;
  logic       r_armed;
  logic       r_press;
  logic       w_full;

  assign w_full  = (r_cnt == LP_DEB);
  assign o_press = r_press;

  // Counter saturates at DEB_CYCLES so a held button fires only once.
  always_ff @(posedge Clk) begin
    if (RES) begin
      r_sync  <= 2'b11;
      r_lvl   <= 1'b1;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_n};
      r_press <= 1'b0;
      if (r_sync[1] != r_lvl) begin
        r_lvl <= r_sync[1];
        r_cnt <= 8'd1;
      end else if (!w_full) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_full && !r_lvl && r_armed) begin
        r_press <= 1'b1;
        r_armed <= 1'b0;
      end else if (w_full && r_lvl) begin
        r_armed <= 1'b1;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       RES,
  input  logic       StartN,
  input  logic       StopN,
  input  logic       LapN,
  input  logic       ScanTick,
  output logic       CntEN,
  output logic       CntCLR,
  output logic       Hold,
  output logic [1:0] DigSel,
  output logic       Running
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
`ifdef STOPWATCH_LAP_EN
  localparam logic [1:0] S_LAP    = 2'd2;
`endif
  localparam logic [1:0] S_PAUSED = 2'd3;

  logic       w_start;
  logic       w_stop;
  logic       w_ev_start;
  logic [1:0] w_nxt;
  logic       w_run_nxt;
  logic [1:0] r_state;
  logic       r_run;
  logic       r_clr;
  logic [1:0] r_dig;

  stopwatch_deb #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .Clk(Clk), .RES(RES), .i_btn_n(StartN), .o_press(w_start)
  );
  stopwatch_deb #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
    .Clk(Clk), .RES(RES), .i_btn_n(StopN), .o_press(w_stop)
  );

  // Stop beats start beats lap when pulses coincide.
  assign w_ev_start = w_start & ~w_stop;

`ifdef STOPWATCH_LAP_EN
  logic w_lap;
  logic w_ev_lap;
  logic r_hold;

  stopwatch_deb #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
    .Clk(Clk), .RES(RES), .i_btn_n(LapN), .o_press(w_lap)
  );

  assign w_ev_lap  = w_lap & ~w_stop & ~w_start;
  assign w_run_nxt = (w_nxt == S_RUN) || (w_nxt == S_LAP);
  assign Hold      = r_hold;

  always_ff @(posedge Clk) begin
    if (RES) r_hold <= 1'b0;
    else     r_hold <= (w_nxt == S_LAP);
  end
`else
  logic w_unused_lap;
  assign w_unused_lap = LapN;
  assign w_run_nxt    = (w_nxt == S_RUN);
  assign Hold         = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_ev_start) w_nxt = S_RUN;
      S_RUN: begin
        if (w_stop) w_nxt = S_PAUSED;
`ifdef STOPWATCH_LAP_EN
        else if (w_ev_lap) w_nxt = S_LAP;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (w_stop) w_nxt = S_PAUSED;
        else if (w_ev_lap) w_nxt = S_RUN;
      end
`endif
      S_PAUSED: begin
        if (w_stop) w_nxt = S_IDLE;
        else if (w_ev_start) w_nxt = S_RUN;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RES) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_clr   <= 1'b1;
      r_dig   <= 2'd0;
    end else begin
      r_state <= w_nxt;
      r_run   <= w_run_nxt;
      r_clr   <= (r_state == S_PAUSED) && w_stop;
      r_dig   <= r_dig + {1'b0, ScanTick};
    end
  end

  assign CntEN   = r_run;
  assign Running = r_run;
  assign CntCLR  = r_clr;
  assign DigSel  = r_dig;
endmodule
